// File: rtl/tl_a_fragment_sequencer.sv
// Replays one buffered TileLink A request as a stream of FRAG-sized fragments.
// Optional fragment performance counter: define FRAG_SEQ_PERF_CNT_EN.
module tl_a_fragment_sequencer #(
  parameter int ADDR_W   = 12,
  parameter int SOURCE_W = 6,
  parameter int MAX_LG   = 6,
  parameter int FRAG_LG  = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_opcode,
  input  logic [2:0]          in_param,
  input  logic [2:0]          in_size,
  input  logic [SOURCE_W-1:0] in_source,
  input  logic [ADDR_W-1:0]   in_address,
  input  logic [7:0]          in_mask,
  input  logic                in_corrupt,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [2:0]          out_opcode,
  output logic [2:0]          out_param,
  output logic [2:0]          out_size,
  output logic [SOURCE_W-1:0] out_source,
  output logic [ADDR_W-1:0]   out_address,
  output logic [7:0]          out_mask,
  output logic                out_corrupt,
  output logic                out_last,
  output logic                busy,
  output logic                err_size
`ifdef FRAG_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]         frag_count
`endif
);

  localparam int CNT_W = MAX_LG - FRAG_LG;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    k_q, k_d;
  logic [CNT_W-1:0]    nlast_q, nlast_d;
  logic                err_size_q, err_size_d;
  logic [2:0]          opcode_q, opcode_d;
  logic [2:0]          param_q, param_d;
  logic [2:0]          size_q, size_d;
  logic [SOURCE_W-1:0] source_q, source_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [7:0]          mask_q, mask_d;
  logic                corrupt_q, corrupt_d;

  logic                send, fire, last, done, accept;
  logic [2:0]          size_clamped;
  logic [ADDR_W-1:0]   offset;

  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    return (int'(s) > MAX_LG) ? 3'(MAX_LG) : s;
  endfunction

  // Index of the final fragment, i.e. nfrag-1.
  function automatic logic [CNT_W-1:0] last_index(input logic [2:0] s);
    if (int'(s) <= FRAG_LG) return '0;
    return CNT_W'((1 << (int'(s) - FRAG_LG)) - 1);
  endfunction

  function automatic logic [2:0] frag_size(input logic [2:0] s);
    return (int'(s) > FRAG_LG) ? 3'(FRAG_LG) : s;
  endfunction

  assign send         = (state_q == SEND);
  assign fire         = send & out_ready;
  assign last         = (k_q == nlast_q);
  assign done         = fire & last;
  assign in_ready     = ~send | done;
  assign accept       = in_valid & in_ready;
  assign size_clamped = clamp_size(in_size);
  assign offset       = ADDR_W'(k_q) << FRAG_LG;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    nlast_d    = nlast_q;
    err_size_d = err_size_q | (accept & (int'(in_size) > MAX_LG));
    if (accept) begin
      state_d = SEND;
      k_d     = '0;
      nlast_d = last_index(size_clamped);
    end else if (done) begin
      state_d = IDLE;
    end else if (fire) begin
      k_d = k_q + 1'b1;
    end
  end

  always_comb begin
    opcode_d  = opcode_q;
    param_d   = param_q;
    size_d    = size_q;
    source_d  = source_q;
    address_d = address_q;
    mask_d    = mask_q;
    corrupt_d = corrupt_q;
    if (accept) begin
      opcode_d  = in_opcode;
      param_d   = in_param;
      size_d    = size_clamped;
      source_d  = in_source;
      address_d = in_address;
      mask_d    = in_mask;
      corrupt_d = in_corrupt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      nlast_q    <= '0;
      err_size_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      nlast_q    <= nlast_d;
      err_size_q <= err_size_d;
    end
  end

  // Captured request fields only matter while SEND, so they carry no reset.
  always_ff @(posedge clock) begin
    opcode_q  <= opcode_d;
    param_q   <= param_d;
    size_q    <= size_d;
    source_q  <= source_d;
    address_q <= address_d;
    mask_q    <= mask_d;
    corrupt_q <= corrupt_d;
  end

  // Outputs are forced to zero while idle so nothing unreset leaks out.
  assign out_valid   = send;
  assign out_opcode  = send ? opcode_q : '0;
  assign out_param   = send ? param_q : '0;
  assign out_size    = send ? frag_size(size_q) : '0;
  assign out_source  = send ? source_q : '0;
  assign out_address = send ? (address_q + offset) : '0;
  assign out_mask    = send ? mask_q : '0;
  assign out_corrupt = send & corrupt_q;
  assign out_last    = send & last;
  assign busy        = send;
  assign err_size    = err_size_q;

`ifdef FRAG_SEQ_PERF_CNT_EN
  logic [15:0] frag_count_q, frag_count_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    frag_count_d = frag_count_q;
    if (fire) frag_count_d = sat_inc(frag_count_q);
  end

  always_ff @(posedge clock) begin
    if (reset) frag_count_q <= '0;
    else       frag_count_q <= frag_count_d;
  end

  assign frag_count = frag_count_q;
`endif

endmodule

// File: tb/tb_tl_a_fragment_sequencer.sv
// Directed bench for tl_a_fragment_sequencer with an expected-fragment scoreboard.
module tb_tl_a_fragment_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  in_opcode, in_param, in_size;
  logic [5:0]  in_source;
  logic [11:0] in_address;
  logic [7:0]  in_mask;
  logic        in_corrupt;
  logic        out_ready, out_valid;
  logic [2:0]  out_opcode, out_param, out_size;
  logic [5:0]  out_source;
  logic [11:0] out_address;
  logic [7:0]  out_mask;
  logic        out_corrupt, out_last, busy, err_size;
`ifdef FRAG_SEQ_PERF_CNT_EN
  logic [15:0] frag_count;
`endif

  int checks   = 0;
  int failures = 0;
  int fires    = 0;

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  size;
    logic [5:0]  src;
    logic [2:0]  op;
    logic        last;
  } exp_t;

  exp_t sb[$];

  tl_a_fragment_sequencer dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_param(in_param), .in_size(in_size), .in_source(in_source),
    .in_address(in_address), .in_mask(in_mask), .in_corrupt(in_corrupt),
    .out_ready(out_ready), .out_valid(out_valid), .out_opcode(out_opcode),
    .out_param(out_param), .out_size(out_size), .out_source(out_source),
    .out_address(out_address), .out_mask(out_mask), .out_corrupt(out_corrupt),
    .out_last(out_last), .busy(busy), .err_size(err_size)
`ifdef FRAG_SEQ_PERF_CNT_EN
    , .frag_count(frag_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expand a request into its expected fragment list.
  task automatic present(input logic [2:0] op, input logic [2:0] size,
                         input logic [11:0] addr, input logic [5:0] src);
    int   s, n;
    exp_t e;
    in_valid = 1'b1; in_opcode = op; in_size = size;
    in_address = addr; in_source = src;
    s = (size > 6) ? 6 : int'(size);
    n = (s <= 3) ? 1 : (1 << (s - 3));
    for (int k = 0; k < n; k++) begin
      e.addr = 12'(int'(addr) + k * 8);
      e.size = (size > 3) ? 3'd3 : size;
      e.src  = src;
      e.op   = op;
      e.last = (k == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic accept_wait();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      fires++;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("frag_addr", out_address, e.addr);
        chk("frag_size", out_size, e.size);
        chk("frag_src", out_source, e.src);
        chk("frag_op", out_opcode, e.op);
        chk("frag_last", out_last, e.last);
        chk("frag_mask", out_mask, 8'hFF);
        chk("frag_corrupt", out_corrupt, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_param = '0; in_size = '0;
    in_source = '0; in_address = '0; in_mask = 8'hFF; in_corrupt = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_size", err_size, 0);
    chk("rst_out_address", out_address, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Single-fragment Get
    out_ready = 1'b1;
    present(3'd4, 3'd3, 12'h040, 6'd5);
    accept_wait();
    @(negedge clock);
    chk("s1_valid", out_valid, 1);
    chk("s1_last", out_last, 1);
    chk("s1_addr", out_address, 12'h040);
    @(posedge clock); #1;
    @(negedge clock);
    chk("s1_idle_busy", busy, 0);
    chk("s1_in_ready", in_ready, 1);

    // Size 6 -> 8 fragments
    @(posedge clock); #1;
    f0 = fires;
    present(3'd4, 3'd6, 12'h100, 6'd0);
    accept_wait();
    drain();
    chk("s2_frag_count", fires - f0, 8);
    chk("s2_busy_after", busy, 0);
`ifdef FRAG_SEQ_PERF_CNT_EN
    chk("perf_count_9", frag_count, 9);
`endif

    // Size 5 with address wrap
    @(posedge clock); #1;
    f0 = fires;
    present(3'd4, 3'd5, 12'hFF0, 6'd2);
    accept_wait();
    drain();
    chk("s3_frag_count", fires - f0, 4);

    // Size 4 with stall, then back-to-back request
    @(posedge clock); #1;
    f0 = fires;
    out_ready = 1'b1;
    present(3'd4, 3'd4, 12'h200, 6'd7);
    accept_wait();
    @(posedge clock); #1;
    out_ready = 1'b0;
    @(negedge clock);
    chk("stall_addr0", out_address, 12'h208);
    chk("stall_last0", out_last, 1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("stall_addr1", out_address, 12'h208);
    chk("stall_valid1", out_valid, 1);
    chk("stall_src1", out_source, 7);
    chk("stall_in_ready", in_ready, 0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    present(3'd1, 3'd3, 12'h300, 6'd9);
    @(negedge clock);
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_addr", out_address, 12'h300);
    drain();
    chk("s4_frag_count", fires - f0, 3);

    // Oversize request, then reset mid-sequence
    @(posedge clock); #1;
    f0 = fires;
    present(3'd4, 3'd7, 12'h000, 6'd3);
    accept_wait();
    @(negedge clock);
    chk("s5_err_size", err_size, 1);
    chk("s5_size", out_size, 3);
    repeat (2) @(negedge clock);
    chk("s5_err_sticky", err_size, 1);
    @(posedge clock); #1;
    chk("s5_fires_before_rst", fires - f0, 3);
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("s5_rst_valid", out_valid, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_err", err_size, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    sb.delete();
    repeat (4) @(negedge clock);
    chk("s5_no_more_valid", out_valid, 0);
    chk("s5_no_more_fires", fires - f0, 3);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
